// File: rtl/bowling_pkg.sv
// rtl/bowling_pkg.sv - shared constants and state encoding for the bowling game sequencer
package bowling_pkg;

  localparam int NUM_FRAMES   = 10;
  localparam int NUM_PINS     = 10;
  localparam int MAX_ROLL_PTS = 30;
  localparam int PTS_W        = 5;
  localparam int FRAME_W      = 4;
  localparam int PIN_W        = 4;
  localparam int IDX_W        = 2;

  typedef enum logic [1:0] {
    WAIT_ROLL = 2'd0,
    EMIT      = 2'd1,
    DONE      = 2'd2
  } state_t;

endpackage

// File: rtl/bowling_frame_ctrl_if.sv
// rtl/bowling_frame_ctrl_if.sv - roll input and point-increment handshakes of the sequencer
interface bowling_frame_ctrl_if;
  import bowling_pkg::*;

  logic             roll_valid;
  logic [PIN_W-1:0] roll_pins;
  logic             roll_ready;
  logic             roll_err;
  logic             add_valid;
  logic [PTS_W-1:0] add_pts;
  logic             add_ready;

  // environment side: roll sensor and score accumulator
  modport master (
    output roll_valid, roll_pins, add_ready,
    input  roll_ready, roll_err, add_valid, add_pts
  );

  // sequencer side
  modport slave (
    input  roll_valid, roll_pins, add_ready,
    output roll_ready, roll_err, add_valid, add_pts
  );

endinterface

// File: rtl/bowl_bonus_tracker.sv
// rtl/bowl_bonus_tracker.sv - strike/spare bonus counters and per-roll multiplier
module bowl_bonus_tracker (
  input  logic       clk,
  input  logic       rst,
  input  logic       accept,
  input  logic       strike,
  input  logic       spare,
  input  logic       final_frame,
  output logic [1:0] mult
);

  // b1: bonuses applying to the next roll; b2: bonuses applying to the roll after
  logic [1:0] b1;
  logic       b2;

  // shift the bonus window by one roll on every legal roll, adding new bonuses
  always_ff @(posedge clk) begin
    if (rst) begin
      b1 <= 2'd0;
      b2 <= 1'b0;
    end else if (accept) begin
      if (final_frame) begin
        b1 <= {1'b0, b2};
        b2 <= 1'b0;
      end else if (strike) begin
        b1 <= {1'b0, b2} + 2'd1;
        b2 <= 1'b1;
      end else if (spare) begin
        b1 <= {1'b0, b2} + 2'd1;
        b2 <= 1'b0;
      end else begin
        b1 <= {1'b0, b2};
        b2 <= 1'b0;
      end
    end
  end

  // b1 never exceeds 2, so the multiplier fits in 2 bits
  assign mult = b1 + 2'd1;

endmodule

// File: rtl/bowling_frame_ctrl.sv
// rtl/bowling_frame_ctrl.sv - bowling game sequencer: frame/roll/pin tracking and point hand-off
module bowling_frame_ctrl
  import bowling_pkg::*;
(
  input  logic               CLOCK_50,
  input  logic               reset,
  bowling_frame_ctrl_if.slave bus,
  output logic [FRAME_W-1:0] frame,
  output logic [IDX_W-1:0]   roll_idx,
  output logic [PIN_W-1:0]   pins_standing,
  output logic               game_over
);

  state_t           state, state_nx;
  logic             accept, legal, take;
  logic             final_frame, clears, strike, spare, last_roll;
  logic             first_strike, last_q, roll_err_q;
  logic [1:0]       mult;
  logic [PTS_W-1:0] pts, add_pts_q;

  assign accept      = (state == WAIT_ROLL) && bus.roll_valid;
  assign legal       = bus.roll_pins <= pins_standing;
  assign take        = accept && legal;
  assign final_frame = frame == FRAME_W'(NUM_FRAMES);
  assign clears      = bus.roll_pins == pins_standing;
  assign strike      = (roll_idx == 2'd0) && (bus.roll_pins == PIN_W'(NUM_PINS));
  assign spare       = (roll_idx == 2'd1) && clears;
  // final frame: roll 2 only after a strike on roll 0 or a spare on roll 1
  assign last_roll   = final_frame &&
                       (((roll_idx == 2'd1) && !first_strike && !clears) || (roll_idx == 2'd2));
  assign pts         = PTS_W'(bus.roll_pins) * PTS_W'(mult);

  bowl_bonus_tracker u_bonus (
    .clk         (CLOCK_50),
    .rst         (reset),
    .accept      (take),
    .strike      (strike),
    .spare       (spare),
    .final_frame (final_frame),
    .mult        (mult)
  );

  // state register
  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= WAIT_ROLL;
    else       state <= state_nx;
  end

  // next state: zero-point rolls skip EMIT entirely
  always_comb begin
    state_nx = state;
    case (state)
      WAIT_ROLL: if (take) begin
        if (pts != '0)     state_nx = EMIT;
        else if (last_roll) state_nx = DONE;
        else               state_nx = WAIT_ROLL;
      end
      EMIT: if (bus.add_ready) state_nx = last_q ? DONE : WAIT_ROLL;
      DONE: state_nx = DONE;
      default: state_nx = WAIT_ROLL;
    endcase
  end

  // frame, roll and rack bookkeeping plus the held increment and error pulse
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      frame         <= FRAME_W'(1);
      roll_idx      <= '0;
      pins_standing <= PIN_W'(NUM_PINS);
      first_strike  <= 1'b0;
      last_q        <= 1'b0;
      add_pts_q     <= '0;
      roll_err_q    <= 1'b0;
    end else begin
      roll_err_q <= accept && !legal;
      if (take) begin
        add_pts_q <= pts;
        last_q    <= last_roll;
        if (roll_idx == 2'd0) first_strike <= strike;
        if (!final_frame) begin
          if (strike || (roll_idx != 2'd0)) begin
            frame         <= frame + FRAME_W'(1);
            roll_idx      <= '0;
            pins_standing <= PIN_W'(NUM_PINS);
          end else begin
            roll_idx      <= 2'd1;
            pins_standing <= pins_standing - bus.roll_pins;
          end
        end else begin
          pins_standing <= clears ? PIN_W'(NUM_PINS) : pins_standing - bus.roll_pins;
          if (roll_idx == 2'd0)                    roll_idx <= 2'd1;
          else if (roll_idx == 2'd1 && !last_roll) roll_idx <= 2'd2;
        end
      end
    end
  end

  assign bus.roll_ready = state == WAIT_ROLL;
  assign bus.add_valid  = state == EMIT;
  assign bus.add_pts    = add_pts_q;
  assign bus.roll_err   = roll_err_q;
  assign game_over      = state == DONE;

endmodule

// File: tb/tb_bowling_frame_ctrl.sv
// tb/tb_bowling_frame_ctrl.sv - scoreboard bench for bowling_frame_ctrl with randomized games
module tb_bowling_frame_ctrl;
  import bowling_pkg::*;

  logic CLOCK_50 = 1'b0;
  logic reset;
  logic [3:0] frame;
  logic [1:0] roll_idx;
  logic [3:0] pins_standing;
  logic       game_over;

  always #5 CLOCK_50 = ~CLOCK_50;

  bowling_frame_ctrl_if bus ();

  bowling_frame_ctrl dut (
    .CLOCK_50      (CLOCK_50),
    .reset         (reset),
    .bus           (bus),
    .frame         (frame),
    .roll_idx      (roll_idx),
    .pins_standing (pins_standing),
    .game_over     (game_over)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int sb[$];
  int ready_mode = 1;   // 0 random, 1 high, 2 low
  int popped_sum = 0;

  // reference model: game position plus a list of open bonus windows
  int m_frame, m_idx, m_pins;
  bit m_first_strike, m_over;
  int win[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic model_reset();
    m_frame = 1; m_idx = 0; m_pins = NUM_PINS;
    m_first_strike = 0; m_over = 0;
    win.delete();
  endtask

  task automatic model_next_frame();
    m_frame++; m_idx = 0; m_pins = NUM_PINS;
  endtask

  // each open window adds one multiple of the roll, then shrinks by one roll
  task automatic model_roll(input int p, output int pts);
    int mult;
    int nw[$];
    bit cleared;
    mult = 1;
    foreach (win[i]) begin
      mult++;
      if (win[i] > 1) nw.push_back(win[i] - 1);
    end
    win = nw;
    pts = p * mult;
    if (m_frame < NUM_FRAMES) begin
      if (m_idx == 0 && p == NUM_PINS) begin
        win.push_back(2);
        model_next_frame();
      end else if (m_idx == 0) begin
        m_pins -= p;
        m_idx = 1;
      end else begin
        if (p == m_pins) win.push_back(1);
        model_next_frame();
      end
    end else begin
      cleared = (p == m_pins);
      m_pins = cleared ? NUM_PINS : m_pins - p;
      if (m_idx == 0) begin
        m_first_strike = (p == NUM_PINS);
        m_idx = 1;
      end else if (m_idx == 1) begin
        if (m_first_strike || cleared) m_idx = 2;
        else m_over = 1;
      end else begin
        m_over = 1;
      end
    end
  endtask

  // monitor: drives add_ready and checks every increment the DUT presents
  bit prev_pend = 0;
  int prev_pts = 0;
  always @(negedge CLOCK_50) begin
    case (ready_mode)
      0:       bus.add_ready = ($urandom % 3) != 0;
      1:       bus.add_ready = 1'b1;
      default: bus.add_ready = 1'b0;
    endcase
    if (reset !== 1'b0) begin
      prev_pend = 0;
    end else if (bus.add_valid) begin
      check("roll_ready_in_emit", bus.roll_ready, 0);
      if (prev_pend) check("add_pts_stable", bus.add_pts, prev_pts);
      if (bus.add_ready) begin
        if (sb.size() == 0) fail_now("unexpected_add_valid");
        else begin
          popped_sum += int'(bus.add_pts);
          check("add_pts", bus.add_pts, sb.pop_front());
        end
      end
      prev_pend = !bus.add_ready;
      prev_pts  = bus.add_pts;
    end else begin
      prev_pend = 0;
    end
  end

  task automatic do_reset();
    @(negedge CLOCK_50);
    reset = 1'b1;
    bus.roll_valid = 1'b0;
    @(negedge CLOCK_50);
    reset = 1'b0;
    model_reset();
    sb.delete();
  endtask

  task automatic play_roll(input int p);
    int  pts;
    int  t;
    bit  legal;
    t = 0;
    while (!bus.roll_ready && t < 100) begin
      @(negedge CLOCK_50);
      t++;
    end
    if (!bus.roll_ready) begin
      fail_now("roll_ready_timeout");
      return;
    end
    legal = p <= m_pins;
    pts = 0;
    if (legal) begin
      model_roll(p, pts);
      if (pts != 0) sb.push_back(pts);
    end
    bus.roll_valid = 1'b1;
    bus.roll_pins  = 4'(p);
    @(negedge CLOCK_50);
    bus.roll_valid = 1'b0;
    check("roll_err", bus.roll_err, !legal);
    check("frame", frame, m_frame);
    check("roll_idx", roll_idx, m_idx);
    check("pins_standing", pins_standing, m_pins);
    if (legal && pts == 0) check("game_over_after_zero", game_over, m_over);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge CLOCK_50);
      t++;
    end
    if (sb.size() != 0) fail_now("scoreboard_drain_timeout");
  endtask

  initial begin
    int p;
    int guard;
    reset = 1'b1;
    bus.roll_valid = 1'b0;
    bus.roll_pins = '0;
    repeat (2) @(negedge CLOCK_50);
    reset = 1'b0;
    model_reset();

    check("rst_roll_ready", bus.roll_ready, 1);
    check("rst_add_valid", bus.add_valid, 0);
    check("rst_add_pts", bus.add_pts, 0);
    check("rst_roll_err", bus.roll_err, 0);
    check("rst_frame", frame, 1);
    check("rst_roll_idx", roll_idx, 0);
    check("rst_pins", pins_standing, NUM_PINS);
    check("rst_game_over", game_over, 0);

    // gutter game
    for (int i = 0; i < 20; i++) play_roll(0);
    check("gutter_game_over", game_over, 1);

    // perfect game
    do_reset();
    popped_sum = 0;
    for (int i = 0; i < 12; i++) play_roll(NUM_PINS);
    wait_drain();
    @(negedge CLOCK_50);
    check("perfect_sum", popped_sum, 300);
    check("perfect_game_over", game_over, 1);
    check("perfect_frame", frame, NUM_FRAMES);
    check("perfect_roll_idx", roll_idx, 2);

    // spare then bonus roll
    do_reset();
    play_roll(7);
    play_roll(3);
    play_roll(4);
    wait_drain();

    // over-count roll rejected
    do_reset();
    play_roll(6);
    play_roll(5);
    check("illegal_ready", bus.roll_ready, 1);
    check("illegal_pins", pins_standing, 4);
    @(negedge CLOCK_50);
    check("roll_err_one_cycle", bus.roll_err, 0);
    wait_drain();

    // accumulator back-pressure
    do_reset();
    ready_mode = 2;
    play_roll(3);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLOCK_50);
      check("stall_add_valid", bus.add_valid, 1);
      check("stall_add_pts", bus.add_pts, 3);
    end
    ready_mode = 1;
    wait_drain();
    @(negedge CLOCK_50);
    check("stall_released", bus.add_valid, 0);

    // reset while an increment is pending in frame 3
    do_reset();
    play_roll(NUM_PINS);
    wait_drain();
    play_roll(NUM_PINS);
    wait_drain();
    ready_mode = 2;
    play_roll(5);
    check("emit_f3_valid", bus.add_valid, 1);
    check("emit_f3_frame", frame, 3);
    reset = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b0;
    check("rst_emit_add_valid", bus.add_valid, 0);
    check("rst_emit_frame", frame, 1);
    check("rst_emit_pins", pins_standing, NUM_PINS);
    model_reset();
    sb.delete();
    ready_mode = 1;
    play_roll(5);
    wait_drain();

    // randomized games with random back-pressure and illegal rolls
    for (int g = 0; g < 8; g++) begin
      do_reset();
      ready_mode = 0;
      guard = 0;
      while (!m_over && guard < 200) begin
        if ($urandom % 5 == 0) p = m_pins + 1 + int'($urandom_range(0, 14 - m_pins));
        else                   p = int'($urandom_range(0, m_pins));
        play_roll(p);
        guard++;
      end
      wait_drain();
      @(negedge CLOCK_50);
      check("rand_game_over", game_over, 1);
      bus.roll_valid = 1'b1;
      bus.roll_pins  = 4'd0;
      repeat (3) begin
        @(negedge CLOCK_50);
        check("done_roll_ready", bus.roll_ready, 0);
        check("done_frame", frame, m_frame);
      end
      bus.roll_valid = 1'b0;
    end

    ready_mode = 1;
    repeat (3) @(negedge CLOCK_50);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
